spi_sram_slave_modal: RTL

//  SPI mode-0 SRAM-emulation slave with a mode register.
//  - Commands: READ 0x03, FAST_READ 0x0B, WRITE 0x02, RDMR 0x05, WRMR 0x01.
//  - Modes: byte, page and sequential addressing.
//  - Sits between the SPI pins (sampled via strobes) and a synchronous byte-wide memory port.
//  - Successor to the fixed 24-bit, sequential-only slave: parametrised width, page size and dummy cycles.

---
 rtl/spi_sram_slave_modal.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_sram_slave_modal.sv
// SPI mode-0 SRAM-emulation slave with a mode register (byte / page / sequential addressing).
// SCK edges arrive as one-clk strobes: en (rising, sample mosi) and en2 (falling, drive miso).
// The memory port strobes are combinational so they line up with the en cycle that triggers them.
module spi_sram_slave_modal #(
    parameter int unsigned ADDR_BITS    = 24,
    parameter int unsigned PAGE_BITS    = 5,
    parameter int unsigned DUMMY_CYCLES = 8,
    parameter logic [1:0]  MODE_RST     = 2'b01
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 en2,
    input  logic                 cs_n,
    input  logic                 mosi,
    output logic                 miso,
    output logic                 miso_oe,
    output logic [1:0]           mode,
    output logic                 err,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_en,
    output logic                 mem_wr,
    output logic [7:0]           mem_wdata,
    input  logic [7:0]           mem_rdata
);

    typedef enum logic [3:0] {
        StIdle, StCmd, StAddr, StDummy, StRdData, StWrData, StRdmr, StWrmr, StIgnore
    } state_e;

    localparam logic [1:0] ModeByte = 2'b00;
    localparam logic [1:0] ModePage = 2'b10;

    state_e                 state_q;
    logic [4:0]             cnt_q;
    logic [6:0]             sh_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic                   wr_q, fast_q, first_q, load_q, rd_pend_q;
    logic [7:0]             rbuf_q;
    logic [6:0]             tx_q;
    logic                   miso_q, oe_q, err_q;
    logic [1:0]             mode_q;

    logic [7:0]             byte_in;
    logic [ADDR_BITS-1:0]   addr_full;
    logic [ADDR_BITS-1:0]   addr_adv;
    logic [PAGE_BITS-1:0]   page_lo;
    logic [7:0]             load_byte;
    logic                   active, addr_last, wr_fire;

    assign byte_in   = {sh_q, mosi};
    assign addr_full = {addr_q[ADDR_BITS-2:0], mosi};
    assign active    = en && !cs_n;
    assign addr_last = (state_q == StAddr) && (cnt_q == 5'(ADDR_BITS - 1));
    // In byte mode only the first data byte of a write reaches memory.
    assign wr_fire   = active && (state_q == StWrData) && (cnt_q == 5'd7) &&
                       !((mode_q == ModeByte) && first_q);
    // A fetch may still be landing in rbuf_q when the first en2 arrives.
    assign load_byte = (state_q == StRdData) ? (rd_pend_q ? mem_rdata : rbuf_q)
                                             : {mode_q, 6'b0};

    // Next address according to the addressing mode (reserved 11 behaves as sequential).
    always_comb begin
        page_lo = addr_q[PAGE_BITS-1:0] + 1'b1;
        case (mode_q)
            ModeByte: addr_adv = addr_q;
            ModePage: addr_adv = {addr_q[ADDR_BITS-1:PAGE_BITS], page_lo};
            default:  addr_adv = addr_q + 1'b1;
        endcase
    end

    // Memory strobes, qualified by the en cycle that issues them.
    always_comb begin
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = byte_in;
        if (active && addr_last && !wr_q) begin
            mem_en   = 1'b1;
            mem_addr = addr_full;
        end else if (active && (state_q == StRdData) && (cnt_q == 5'd6)) begin
            // Prefetch the next byte one bit early so it is ready at the byte boundary.
            mem_en   = 1'b1;
            mem_addr = addr_adv;
        end else if (wr_fire) begin
            mem_en = 1'b1;
            mem_wr = 1'b1;
        end
    end

    // Protocol FSM plus registered miso/miso_oe/err/mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            sh_q      <= '0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            fast_q    <= 1'b0;
            first_q   <= 1'b0;
            load_q    <= 1'b0;
            rd_pend_q <= 1'b0;
            rbuf_q    <= '0;
            tx_q      <= '0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            err_q     <= 1'b0;
            mode_q    <= MODE_RST;
        end else begin
            err_q     <= 1'b0;
            rd_pend_q <= mem_en && !mem_wr;
            if (rd_pend_q) rbuf_q <= mem_rdata;
            if (en) begin
                if (cs_n) begin
                    if (state_q == StCmd || state_q == StAddr) err_q <= 1'b1;
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end else begin
                    sh_q  <= byte_in[6:0];
                    cnt_q <= cnt_q + 5'd1;
                    case (state_q)
                        StIdle: begin
                            state_q <= StCmd;
                            cnt_q   <= 5'd1;
                        end
                        StCmd: begin
                            if (cnt_q == 5'd7) begin
                                cnt_q <= '0;
                                case (byte_in)
                                    8'h03: begin state_q <= StAddr; wr_q <= 1'b0; fast_q <= 1'b0; end
                                    8'h0B: begin state_q <= StAddr; wr_q <= 1'b0; fast_q <= 1'b1; end
                                    8'h02: begin state_q <= StAddr; wr_q <= 1'b1; fast_q <= 1'b0; end
                                    8'h05: begin state_q <= StRdmr; load_q <= 1'b1; end
                                    8'h01: state_q <= StWrmr;
                                    default: begin state_q <= StIgnore; err_q <= 1'b1; end
                                endcase
                            end
                        end
                        StAddr: begin
                            addr_q <= addr_full;
                            if (addr_last) begin
                                cnt_q   <= '0;
                                first_q <= 1'b0;
                                load_q  <= 1'b1;
                                if (wr_q) state_q <= StWrData;
                                else if (fast_q && DUMMY_CYCLES != 0) state_q <= StDummy;
                                else state_q <= StRdData;
                            end
                        end
                        StDummy: begin
                            if (cnt_q == 5'(DUMMY_CYCLES - 1)) begin
                                cnt_q   <= '0;
                                state_q <= StRdData;
                            end
                        end
                        StRdData, StRdmr: begin
                            if (state_q == StRdData && cnt_q == 5'd6) addr_q <= addr_adv;
                            if (cnt_q == 5'd7) begin
                                cnt_q  <= '0;
                                load_q <= 1'b1;
                            end
                        end
                        StWrData: begin
                            if (cnt_q == 5'd7) begin
                                cnt_q   <= '0;
                                addr_q  <= addr_adv;
                                first_q <= 1'b1;
                            end
                        end
                        StWrmr: begin
                            if (cnt_q == 5'd7) begin
                                mode_q  <= byte_in[7:6];
                                state_q <= StIgnore;
                            end
                        end
                        default: ;
                    endcase
                end
            end else if (en2) begin
                if (state_q == StRdData || state_q == StRdmr) begin
                    oe_q <= 1'b1;
                    if (load_q) begin
                        miso_q <= load_byte[7];
                        tx_q   <= load_byte[6:0];
                        load_q <= 1'b0;
                    end else begin
                        miso_q <= tx_q[6];
                        tx_q   <= {tx_q[5:0], 1'b0};
                    end
                end else begin
                    oe_q   <= 1'b0;
                    miso_q <= 1'b0;
                end
            end
        end
    end

    assign miso    = miso_q;
    assign miso_oe = oe_q;
    assign err     = err_q;
    assign mode    = mode_q;

endmodule
